// File: rtl/enemy_wave_scheduler_if.sv
// Pixel plotter request/acknowledge channel shared by the enemy wave scheduler.
interface enemy_wave_scheduler_if;
   logic       draw_req;
   logic       draw_ack;
   logic [7:0] draw_x;
   logic [6:0] draw_y;
   logic       draw_erase;
   logic [2:0] draw_id;

   modport master (output draw_req, draw_x, draw_y, draw_erase, draw_id, input draw_ack);
   modport slave  (input draw_req, draw_x, draw_y, draw_erase, draw_id, output draw_ack);
endinterface

// File: rtl/enemy_wave_scheduler.sv
// Moves and redraws a wave of bouncing enemies once per movement tick via the shared plotter.
// Optional ENEMY_SPEEDUP_EN: divider reload shrinks to TICK_COUNT >> (dead slots).
//
// state   | meaning
// S_IDLE  | waiting for movement tick
// S_SCAN  | find lowest alive slot >= ptr
// S_ERASE | plot current slot in background colour at old x
// S_MOVE  | step x / bounce at screen edges
// S_DRAW  | plot current slot in enemy colour at new x
// S_DONE  | pass finished, back to idle
module enemy_wave_scheduler #(
   parameter int          NUM_ENEMIES = 4,
   parameter logic [27:0] TICK_COUNT  = 28'd24_999_999,
   parameter int          X_MAX       = 160,
   parameter int          Y_BASE      = 8,
   parameter int          Y_SPACING   = 8
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   start_game,
   input  logic                   kill_valid,
   input  logic [2:0]             kill_id,
   enemy_wave_scheduler_if.master draw,
   output logic [NUM_ENEMIES-1:0] alive_mask,
   output logic                   wave_cleared,
   output logic                   tick_overrun
);
   localparam int N = NUM_ENEMIES;
   localparam logic [7:0] X_LAST = 8'(X_MAX - 1);

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ERASE, S_MOVE, S_DRAW, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    ptr_q, ptr_d;
   logic [7:0]    x_q [N];
   logic [7:0]    x_d [N];
   logic [N-1:0]  dir_q, dir_d;
   logic [N-1:0]  alive_q, alive_d;
   logic [27:0]   div_q, div_d, reload;
   logic          req_q, req_d, erase_q, erase_d;
   logic [7:0]    px_q, px_d;
   logic [6:0]    py_q, py_d;
   logic [2:0]    id_q, id_d;
   logic          overrun_q, overrun_d, cleared_q, cleared_d;

   logic          tick, kill_hit, cur_kill, cur_dead, found, cur_dir;
   logic [3:0]    sel;
   logic [7:0]    cur_x, alive_ext;
   logic [6:0]    cur_y;

`ifdef ENEMY_SPEEDUP_EN
   logic [3:0] dead_cnt;
   always_comb begin
      dead_cnt = '0;
      for (int i = 0; i < N; i++)
         if (!alive_q[i]) dead_cnt = dead_cnt + 4'd1;
   end
   assign reload = TICK_COUNT >> dead_cnt;
`else
   assign reload = TICK_COUNT;
`endif

   assign tick      = (div_q == '0);
   assign kill_hit  = kill_valid && (int'(kill_id) < N);
   assign cur_kill  = kill_hit && ({1'b0, kill_id} == ptr_q);
   assign alive_ext = 8'(alive_q);
   assign cur_dead  = !alive_ext[ptr_q[2:0]] || cur_kill;
   assign cur_y     = 7'(Y_BASE + int'(ptr_q) * Y_SPACING);

   always_comb begin
      cur_x   = '0;
      cur_dir = 1'b0;
      found   = 1'b0;
      sel     = '0;
      for (int i = 0; i < N; i++)
         if (ptr_q == 4'(i)) begin
            cur_x   = x_q[i];
            cur_dir = dir_q[i];
         end
      // Descending walk so the lowest qualifying slot wins.
      for (int i = N - 1; i >= 0; i--)
         if (alive_q[i] && (4'(i) >= ptr_q)) begin
            found = 1'b1;
            sel   = 4'(i);
         end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      x_d       = x_q;
      dir_d     = dir_q;
      alive_d   = alive_q;
      div_d     = tick ? reload : div_q - 28'd1;
      req_d     = req_q;
      px_d      = px_q;
      py_d      = py_q;
      erase_d   = erase_q;
      id_d      = id_q;
      overrun_d = overrun_q | (tick && (state_q != S_IDLE));

      for (int i = 0; i < N; i++)
         if (kill_hit && (int'(kill_id) == i)) alive_d[i] = 1'b0;
      cleared_d = (alive_q != '0) && (alive_d == '0);

      case (state_q)
         S_IDLE: if (tick && (alive_q != '0)) begin
            state_d = S_SCAN;
            ptr_d   = '0;
         end
         S_SCAN: if (found) begin
            ptr_d   = sel;
            state_d = S_ERASE;
         end else begin
            state_d = S_DONE;
         end
         S_ERASE: if (!req_q) begin
            req_d   = 1'b1;
            px_d    = cur_x;
            py_d    = cur_y;
            erase_d = 1'b1;
            id_d    = ptr_q[2:0];
         end else if (draw.draw_ack) begin
            req_d = 1'b0;
            if (cur_dead) begin
               ptr_d   = ptr_q + 4'd1;
               state_d = S_SCAN;
            end else begin
               state_d = S_MOVE;
            end
         end
         S_MOVE: if (cur_dead) begin
            ptr_d   = ptr_q + 4'd1;
            state_d = S_SCAN;
         end else begin
            for (int i = 0; i < N; i++)
               if (ptr_q == 4'(i)) begin
                  if (!cur_dir && (cur_x == X_LAST)) begin
                     dir_d[i] = 1'b1;
                     x_d[i]   = X_LAST - 8'd1;
                  end else if (cur_dir && (cur_x == 8'd0)) begin
                     dir_d[i] = 1'b0;
                     x_d[i]   = 8'd1;
                  end else begin
                     x_d[i] = cur_dir ? cur_x - 8'd1 : cur_x + 8'd1;
                  end
               end
            state_d = S_DRAW;
         end
         S_DRAW: if (!req_q) begin
            if (cur_dead) begin
               ptr_d   = ptr_q + 4'd1;
               state_d = S_SCAN;
            end else begin
               req_d   = 1'b1;
               px_d    = cur_x;
               py_d    = cur_y;
               erase_d = 1'b0;
               id_d    = ptr_q[2:0];
            end
         end else begin
            // Killed with the redraw already offered: finish the transfer as an erase.
            if (cur_kill) erase_d = 1'b1;
            if (draw.draw_ack) begin
               req_d   = 1'b0;
               ptr_d   = ptr_q + 4'd1;
               state_d = S_SCAN;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (start_game) begin
         state_d   = S_IDLE;
         ptr_d     = '0;
         for (int i = 0; i < N; i++) x_d[i] = 8'(i * (X_MAX / N));
         dir_d     = '0;
         alive_d   = '1;
         div_d     = TICK_COUNT;
         req_d     = 1'b0;
         px_d      = '0;
         py_d      = '0;
         erase_d   = 1'b0;
         id_d      = '0;
         overrun_d = 1'b0;
         cleared_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         for (int i = 0; i < N; i++) x_q[i] <= 8'(i * (X_MAX / N));
         dir_q     <= '0;
         alive_q   <= '1;
         div_q     <= TICK_COUNT;
         req_q     <= 1'b0;
         px_q      <= '0;
         py_q      <= '0;
         erase_q   <= 1'b0;
         id_q      <= '0;
         overrun_q <= 1'b0;
         cleared_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         x_q       <= x_d;
         dir_q     <= dir_d;
         alive_q   <= alive_d;
         div_q     <= div_d;
         req_q     <= req_d;
         px_q      <= px_d;
         py_q      <= py_d;
         erase_q   <= erase_d;
         id_q      <= id_d;
         overrun_q <= overrun_d;
         cleared_q <= cleared_d;
      end
   end

   assign draw.draw_req   = req_q;
   assign draw.draw_x     = px_q;
   assign draw.draw_y     = py_q;
   assign draw.draw_erase = erase_q;
   assign draw.draw_id    = id_q;
   assign alive_mask      = alive_q;
   assign wave_cleared    = cleared_q;
   assign tick_overrun    = overrun_q;
endmodule
